// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory signals of the program loader.
// Handshake: a byte transfers on a rising edge where ByteValid and ByteReady are both high;
// the source holds ByteData stable while ByteValid is high, and ByteReady never depends on ByteValid.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              Start;
    logic [ADDR_W:0]   Length;
    logic [7:0]        ByteData;
    logic              ByteValid;
    logic              ByteReady;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWdata;
    logic              Busy;
    logic              Done;

    modport master (
        output Start, Length, ByteData, ByteValid,
        input  ByteReady, MemWe, MemAddr, MemWdata, Busy, Done
    );

    modport slave (
        input  Start, Length, ByteData, ByteValid,
        output ByteReady, MemWe, MemAddr, MemWdata, Busy, Done
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a program into instruction memory from a byte stream: four bytes little-endian
// per word, one write cycle per word, then a one-cycle Done pulse.
module instr_mem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_mem_loader_if.slave  bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [ADDR_W:0]   len_start;
    logic              accept;
    logic              last_word;

    // Clamp the requested length so the address can never run past the memory.
    assign len_start = (bus.Length > DEPTH_L) ? DEPTH_L : bus.Length;
    assign accept    = (state == RECV) && bus.ByteValid;
    assign last_word = (({1'b0, word_idx} + (ADDR_W+1)'(1)) == len_q);

    assign bus.ByteReady = (state == RECV);
    assign bus.MemWe     = (state == WRITE);
    assign bus.Busy      = (state == RECV) || (state == WRITE);
    assign bus.Done      = (state == DONE);
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemWdata  = mem_wdata_q;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = (len_start == '0) ? DONE : RECV;
            RECV:    if (accept && (byte_cnt == 2'd3)) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : RECV;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The write address/data registers load when byte 3 arrives, so they are
    // valid during WRITE and keep the last written values afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            asm_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        len_q    <= len_start;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= bus.ByteData;
                            2'd1: asm_q[15:8]  <= bus.ByteData;
                            2'd2: asm_q[23:16] <= bus.ByteData;
                            default: begin
                                mem_addr_q  <= word_idx;
                                mem_wdata_q <= {bus.ByteData, asm_q};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + ADDR_W'(1);
                        byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
